truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Sequencer that drives a combinational gate under test (Not, And, Xor and similar gate modules) through every input combination, one vector at a time.
- Waits a programmable settle time per vector, samples the gate output and compares it against a parameterised expected truth table.
- Reports mismatch count, first failing vector and pass/fail through a start/done handshake.
- Replaces hand-written per-gate stimulus with one reusable, synthesizable checker.

Parameters:
- IN_W, 2, gate input width; legal range 1..4; vectors 0..2^IN_W-1.
- SETTLE, 1, idle cycles per vector before the check cycle; legal range 0..15.
- EXPECT, 4'b0110, expected truth table, width 2^IN_W. Bit i is the expected gate output when dut_in == i. Example: Not with IN_W=1 uses EXPECT=2'b01.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current run.
- dut_out  input  1  output of the gate under test.
- dut_in  output  IN_W  vector driven to the gate under test.
- busy  output  1  high while a run is in progress.
- sample_valid  output  1  one-cycle pulse in each CHECK cycle.
- done  output  1  one-cycle pulse at the end of a completed run.
- pass  output  1  1 when err_cnt==0 at completion; held until the next start.
- err_cnt  output  IN_W+1  number of mismatching vectors.
- fail_idx  output  IN_W  first mismatching vector; 0 if none.

Behaviour:
- Reset, synchronous, when rst_n==0 at a rising edge:
  - state=IDLE.
  - dut_in, busy, sample_valid, done, pass, err_cnt, fail_idx all 0.
  - Settle counter = 0.
  - rst_n overrides start and abort.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 → clear err_cnt, fail_idx and pass; dut_in=0.
  - Next state is SETTLE with counter=SETTLE-1 if SETTLE>0, else CHECK.
- SETTLE:
  - busy=1, dut_in held.
  - Counter decrements each cycle; at 0 → CHECK.
- CHECK (one cycle):
  - busy=1, sample_valid=1.
  - At the closing edge, compare dut_out with EXPECT[dut_in].
  - On mismatch: err_cnt++. If this is the first mismatch, fail_idx=dut_in.
  - If dut_in==2^IN_W-1 → DONE.
  - Otherwise dut_in++ and go to SETTLE (counter reloaded) or to CHECK when SETTLE==0.
- DONE (one cycle):
  - done=1, busy=1, pass=(err_cnt==0).
  - Then IDLE, with dut_in returned to 0.
- Timing:
  - Each vector is held for SETTLE+1 cycles; dut_out is sampled on the last of them.
  - Run length is 2^IN_W*(SETTLE+1) cycles, then the DONE cycle.
  - done is asserted in cycle 1+2^IN_W*(SETTLE+1), counting the edge that accepted start as edge 0.
- Boundaries:
  - start while not in IDLE is ignored, including in the DONE cycle.
  - abort=1 in SETTLE, CHECK or DONE → IDLE on the next edge, with dut_in=0, pass=0 and no done pulse. err_cnt and fail_idx keep their partial values.
  - abort in IDLE has no effect. abort overrides start in the same cycle.
  - A CHECK coinciding with abort does not update err_cnt.
  - err_cnt maximum is 2^IN_W, which fits in IN_W+1 bits; no wrap.
  - dut_in never wraps inside a run; the last vector goes to DONE.
  - Mid-run reset gives the full reset values on the next edge.
- dut_out is treated as combinational from dut_in. It must not be sampled outside CHECK; glitches in SETTLE are ignored.

Test Plan:
- Default parameters, ideal Xor model, start pulse at edge 0 → dut_in sequence 0,0,1,1,2,2,3,3; sample_valid in cycles 2,4,6,8; done in cycle 9 with pass=1, err_cnt=0, fail_idx=0.
- Default parameters, gate output stuck at 0 → err_cnt=2, fail_idx=1, pass=0 at done.
- IN_W=1, SETTLE=0, EXPECT=2'b01, ideal Not model → done 3 cycles after the start edge, pass=1. Repeat with a buffer model instead of Not → err_cnt=2, fail_idx=0.
- start held high through a whole run, and reasserted in the DONE cycle → exactly one run. After IDLE, a new start clears err_cnt/pass and a second run completes.
- abort asserted in cycle 5 of a default run → IDLE in cycle 6, busy=0, dut_in=0, no done pulse, pass=0.
- rst_n=0 in cycle 4 of a run with a stuck-at-0 gate → all outputs 0 next cycle, err_cnt=0, state IDLE; start afterwards behaves as a fresh run.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Handshake and gate-side signal bundle for truth_table_sequencer.
// The master modport is the sequencer; the slave side holds start/abort and the gate output.
interface truth_table_sequencer_if #(
  parameter int IN_W = 2
);
  logic            start;
  logic            abort;
  logic            dut_out;
  logic [IN_W-1:0] dut_in;
  logic            busy;
  logic            sample_valid;
  logic            done;
  logic            pass;
  logic [IN_W:0]   err_cnt;
  logic [IN_W-1:0] fail_idx;

  modport master (
    input  start, abort, dut_out,
    output dut_in, busy, sample_valid, done, pass, err_cnt, fail_idx
  );

  modport slave (
    output start, abort, dut_out,
    input  dut_in, busy, sample_valid, done, pass, err_cnt, fail_idx
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks a combinational gate through every input vector, waits a settle time per vector
// and compares the sampled output against an expected truth table.
module truth_table_sequencer #(
  parameter int                   IN_W   = 2,
  parameter int                   SETTLE = 1,
  parameter logic [(1<<IN_W)-1:0] EXPECT = 4'b0110
) (
  input logic                     clk,
  input logic                     rst_n,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam int              NVEC     = 1 << IN_W;
  localparam logic [IN_W-1:0] LAST_VEC = IN_W'(NVEC - 1);
  localparam logic [IN_W-1:0] VEC_ONE  = IN_W'(1);
  localparam logic [IN_W:0]   ERR_ONE  = (IN_W + 1)'(1);
  localparam logic [3:0]      CNT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam state_t          FIRST_ST = (SETTLE > 0) ? S_SETTLE : S_CHECK;

  state_t          state, next_state;
  logic [3:0]      cnt_q, cnt_d;
  logic [IN_W-1:0] vec_q, vec_d;
  logic [IN_W:0]   err_q, err_d;
  logic [IN_W-1:0] fail_q, fail_d;
  logic            pass_q, pass_d;
  logic            busy_c, valid_c, done_c;
  logic            mismatch;

  assign mismatch = (bus.dut_out != EXPECT[vec_q]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      vec_q  <= '0;
      err_q  <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= next_state;
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      pass_q <= pass_d;
    end
  end

  // abort beats everything except reset; a CHECK cut short by abort leaves err_cnt untouched
  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    busy_c     = 1'b0;
    valid_c    = 1'b0;
    done_c     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          cnt_d      = CNT_LOAD;
          next_state = FIRST_ST;
        end
      end

      S_SETTLE: begin
        busy_c = 1'b1;
        if (bus.abort) begin
          vec_d      = '0;
          pass_d     = 1'b0;
          next_state = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          next_state = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_CHECK: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        if (bus.abort) begin
          vec_d      = '0;
          pass_d     = 1'b0;
          next_state = S_IDLE;
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) fail_d = vec_q;
          end
          if (vec_q == LAST_VEC) begin
            pass_d     = (err_q == '0) && !mismatch;
            next_state = S_DONE;
          end else begin
            vec_d      = vec_q + VEC_ONE;
            cnt_d      = CNT_LOAD;
            next_state = FIRST_ST;
          end
        end
      end

      S_DONE: begin
        busy_c     = 1'b1;
        done_c     = !bus.abort;
        vec_d      = '0;
        next_state = S_IDLE;
        if (bus.abort) pass_d = 1'b0;
      end

      default: next_state = S_IDLE;
    endcase
  end

  assign bus.dut_in       = vec_q;
  assign bus.busy         = busy_c;
  assign bus.sample_valid = valid_c;
  assign bus.done         = done_c;
  assign bus.pass         = pass_q;
  assign bus.err_cnt      = err_q;
  assign bus.fail_idx     = fail_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: a default-parameter sequencer on an Xor model and a 1-bit sequencer
// on a Not model, with stuck/buffer fault modes, aborts and mid-run reset.
module tb_truth_table_sequencer;

  logic clk;
  logic rst_n;
  logic gate2_stuck;
  logic gate1_buf;
  int   checks;
  int   errors;

  truth_table_sequencer_if #(.IN_W(2)) bus2 ();
  truth_table_sequencer_if #(.IN_W(1)) bus1 ();

  assign bus2.dut_out = gate2_stuck ? 1'b0 : (bus2.dut_in[1] ^ bus2.dut_in[0]);
  assign bus1.dut_out = gate1_buf ? bus1.dut_in[0] : ~bus1.dut_in[0];

  truth_table_sequencer #(.IN_W(2), .SETTLE(1), .EXPECT(4'b0110)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.master)
  );

  truth_table_sequencer #(.IN_W(1), .SETTLE(0), .EXPECT(2'b01)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge, then the bench advances to the next falling edge.
  task automatic applyStimulus(input logic s2, input logic a2, input logic s1, input logic r);
    bus2.start  = s2;
    bus2.abort  = a2;
    bus1.start  = s1;
    bus1.abort  = 1'b0;
    rst_n       = r;
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    gate2_stuck = 1'b0;
    gate1_buf   = 1'b0;
    bus2.start  = 1'b0;
    bus2.abort  = 1'b0;
    bus1.start  = 1'b0;
    bus1.abort  = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] reset state");
    checkOutput("rst_busy",   bus2.busy,         0);
    checkOutput("rst_dutin",  bus2.dut_in,       0);
    checkOutput("rst_valid",  bus2.sample_valid, 0);
    checkOutput("rst_done",   bus2.done,         0);
    checkOutput("rst_pass",   bus2.pass,         0);
    checkOutput("rst_err",    bus2.err_cnt,      0);
    checkOutput("rst_fail",   bus2.fail_idx,     0);
    checkOutput("rst1_busy",  bus1.busy,         0);

    $display("[TB] run 1: ideal Xor, start pulse");
    applyStimulus(1, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("r1_dutin_c%0d", k), bus2.dut_in, (k - 1) / 2);
      checkOutput($sformatf("r1_valid_c%0d", k), bus2.sample_valid, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("r1_busy_c%0d", k),  bus2.busy, 1);
      checkOutput($sformatf("r1_done_c%0d", k),  bus2.done, 0);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("r1_done",  bus2.done,     1);
    checkOutput("r1_busyd", bus2.busy,     1);
    checkOutput("r1_pass",  bus2.pass,     1);
    checkOutput("r1_err",   bus2.err_cnt,  0);
    checkOutput("r1_fail",  bus2.fail_idx, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("r1_idle_busy", bus2.busy,   0);
    checkOutput("r1_idle_done", bus2.done,   0);
    checkOutput("r1_idle_in",   bus2.dut_in, 0);
    checkOutput("r1_idle_pass", bus2.pass,   1);

    $display("[TB] run 2: stuck-at-0, start held through DONE");
    gate2_stuck = 1'b1;
    applyStimulus(1, 0, 0, 1);
    checkOutput("r2_pass_clr", bus2.pass,    0);
    checkOutput("r2_busy",     bus2.busy,    1);
    for (int k = 1; k <= 8; k++) applyStimulus(1, 0, 0, 1);
    checkOutput("r2_done", bus2.done,     1);
    checkOutput("r2_err",  bus2.err_cnt,  2);
    checkOutput("r2_fail", bus2.fail_idx, 1);
    checkOutput("r2_pass", bus2.pass,     0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("r2_idle_busy", bus2.busy, 0);
    checkOutput("r2_idle_done", bus2.done, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("r2_norerun_busy", bus2.busy,    0);
    checkOutput("r2_keep_err",     bus2.err_cnt, 2);

    $display("[TB] run 3: fresh start clears results");
    gate2_stuck = 1'b0;
    applyStimulus(1, 0, 0, 1);
    checkOutput("r3_err_clr",  bus2.err_cnt,  0);
    checkOutput("r3_fail_clr", bus2.fail_idx, 0);
    for (int k = 1; k <= 8; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("r3_done", bus2.done, 1);
    checkOutput("r3_pass", bus2.pass, 1);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] abort in cycle 5");
    gate2_stuck = 1'b1;
    applyStimulus(1, 0, 0, 1);
    for (int k = 1; k <= 4; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("ab_c5_in",  bus2.dut_in,  2);
    checkOutput("ab_c5_err", bus2.err_cnt, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("ab_busy", bus2.busy,     0);
    checkOutput("ab_in",   bus2.dut_in,   0);
    checkOutput("ab_pass", bus2.pass,     0);
    checkOutput("ab_err",  bus2.err_cnt,  1);
    checkOutput("ab_fail", bus2.fail_idx, 1);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("ab_nodone_%0d", k), bus2.done, 0);
      checkOutput($sformatf("ab_nobusy_%0d", k), bus2.busy, 0);
      applyStimulus(0, 0, 0, 1);
    end

    $display("[TB] abort during a failing CHECK");
    applyStimulus(1, 0, 0, 1);
    for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("abc_valid", bus2.sample_valid, 1);
    checkOutput("abc_in",    bus2.dut_in,       1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("abc_err",  bus2.err_cnt, 0);
    checkOutput("abc_busy", bus2.busy,    0);

    $display("[TB] abort overrides start in IDLE");
    applyStimulus(1, 1, 0, 1);
    checkOutput("abs_busy", bus2.busy, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abs_busy2", bus2.busy, 0);

    $display("[TB] mid-run reset");
    applyStimulus(1, 0, 0, 1);
    for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("mr_busy",  bus2.busy,         0);
    checkOutput("mr_in",    bus2.dut_in,       0);
    checkOutput("mr_valid", bus2.sample_valid, 0);
    checkOutput("mr_err",   bus2.err_cnt,      0);
    checkOutput("mr_fail",  bus2.fail_idx,     0);
    checkOutput("mr_pass",  bus2.pass,         0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("mr_idle", bus2.busy, 0);
    gate2_stuck = 1'b0;
    applyStimulus(1, 0, 0, 1);
    checkOutput("mr_run_in", bus2.dut_in, 0);
    for (int k = 1; k <= 8; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("mr_run_done", bus2.done, 1);
    checkOutput("mr_run_pass", bus2.pass, 1);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] IN_W=1 Not");
    applyStimulus(0, 0, 1, 1);
    checkOutput("n1_c1_in",    bus1.dut_in,       0);
    checkOutput("n1_c1_valid", bus1.sample_valid, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("n1_c2_in",    bus1.dut_in,       1);
    checkOutput("n1_c2_done",  bus1.done,         0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("n1_done", bus1.done,    1);
    checkOutput("n1_pass", bus1.pass,    1);
    checkOutput("n1_err",  bus1.err_cnt, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("n1_idle", bus1.busy, 0);

    $display("[TB] IN_W=1 buffer");
    gate1_buf = 1'b1;
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("b1_done", bus1.done,     1);
    checkOutput("b1_err",  bus1.err_cnt,  2);
    checkOutput("b1_fail", bus1.fail_idx, 0);
    checkOutput("b1_pass", bus1.pass,     0);
    applyStimulus(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
